// File: rtl/nvdla_tcdm_responder.sv
// nvdla_tcdm_responder
//   Multi-port TCDM slave memory model that answers the NVDLA HWPE streamer's
//   tcdm[] master ports. Memory is word-interleaved across N_BANKS banks.
//   Each bank runs its own round-robin arbiter. Reads return one cycle after
//   the grant.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous clear of rr pointers and response regs
//   tcdm_req_i[MP]    request            tcdm_gnt_o[MP]     same-cycle grant
//   tcdm_add_i[MP]    byte address       tcdm_wen_i[MP]     1 = read, 0 = write
//   tcdm_be_i[MP]     write byte enables tcdm_data_i[MP]    write data
//   tcdm_r_data_o[MP] read data          tcdm_r_valid_o[MP] grant delayed 1 cycle
//
// Build option
//   NVDLA_TCDM_STALL_EN  adds a 16-bit LFSR that randomly blanks all grants,
//                        which stresses the streamer's back-pressure handling.

// One bank: round-robin arbiter, rr pointer and byte-writable storage.
module nvdla_tcdm_bank #(
  parameter int MP    = 3,
  parameter int ROW_W = 8,
  parameter int RR_W  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      stall_i,
  input  logic [MP-1:0]             req_i,
  input  logic [MP-1:0]             wen_i,
  input  logic [MP-1:0][ROW_W-1:0]  row_i,
  input  logic [MP-1:0][3:0]        be_i,
  input  logic [MP-1:0][31:0]       wdata_i,
  output logic [MP-1:0]             gnt_o,
  output logic [31:0]               rdata_o
);
  localparam int ROWS = 2 ** ROW_W;

  logic [RR_W-1:0] rr_q, rr_d;
  logic [RR_W-1:0] win;
  logic            any_req;
  logic            go;
  int              idx;
  logic [31:0]     mem_q [ROWS];

  // First requester at or after the rr pointer, scanning upward with wrap.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < MP; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= MP) idx = idx - MP;
      if (!any_req && req_i[idx]) begin
        win     = RR_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  // A stalled cycle behaves as if the bank were idle.
  assign go = any_req && !stall_i;

  always_comb begin
    gnt_o = '0;
    if (go) gnt_o[win] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (go) rr_d = (int'(win) == MP - 1) ? '0 : RR_W'(win + 1'b1);
    if (clear_i) rr_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  // Combinational read gives the pre-write contents; the top registers it.
  assign rdata_o = mem_q[row_i[win]];

  // Storage has no reset. A write still lands during clear_i.
  always_ff @(posedge clk_i) begin
    if (go && !wen_i[win]) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[win][b]) mem_q[row_i[win]][8*b +: 8] <= wdata_i[win][8*b +: 8];
      end
    end
  end
endmodule

module nvdla_tcdm_responder #(
  parameter int MP        = 3,
  parameter int N_BANKS   = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [MP-1:0]         tcdm_req_i,
  output logic [MP-1:0]         tcdm_gnt_o,
  input  logic [MP-1:0][31:0]   tcdm_add_i,
  input  logic [MP-1:0]         tcdm_wen_i,
  input  logic [MP-1:0][3:0]    tcdm_be_i,
  input  logic [MP-1:0][31:0]   tcdm_data_i,
  output logic [MP-1:0][31:0]   tcdm_r_data_o,
  output logic [MP-1:0]         tcdm_r_valid_o
);
  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int BANK_W = $clog2(N_BANKS);
  localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int RR_W   = (MP > 1) ? $clog2(MP) : 1;

  logic [MP-1:0][ADDR_W-1:0]     word;
  logic [MP-1:0][SEL_W-1:0]      bank_sel;
  logic [MP-1:0][ROW_W-1:0]      row;
  logic [MP-1:0]                 unused_add;
  logic [N_BANKS-1:0][MP-1:0]    bank_req;
  logic [N_BANKS-1:0][MP-1:0]    bank_gnt;
  logic [N_BANKS-1:0][31:0]      bank_rdata;
  logic                          stall;

  logic [MP-1:0]                 r_valid_q, r_valid_d;
  logic [MP-1:0][31:0]           r_data_q, r_data_d;

  // Address decode. Upper bits drop out, so addresses alias modulo the memory.
  for (genvar p = 0; p < MP; p++) begin : g_dec
    assign word[p]       = tcdm_add_i[p][ADDR_W+1:2];
    assign row[p]        = word[p][ADDR_W-1:BANK_W];
    assign unused_add[p] = ^{tcdm_add_i[p][31:ADDR_W+2], tcdm_add_i[p][1:0]};
    if (BANK_W > 0) begin : g_sel
      assign bank_sel[p] = word[p][SEL_W-1:0];
    end else begin : g_nosel
      assign bank_sel[p] = '0;
    end
  end

`ifdef NVDLA_TCDM_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11. Bit 0 set means the cycle is stalled.
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (clear_i) lfsr_d = 16'hACE1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < N_BANKS; b++)
      for (int p = 0; p < MP; p++)
        bank_req[b][p] = tcdm_req_i[p] && (bank_sel[p] == SEL_W'(b));
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    nvdla_tcdm_bank #(
      .MP    (MP),
      .ROW_W (ROW_W),
      .RR_W  (RR_W)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .stall_i (stall),
      .req_i   (bank_req[b]),
      .wen_i   (tcdm_wen_i),
      .row_i   (row),
      .be_i    (tcdm_be_i),
      .wdata_i (tcdm_data_i),
      .gnt_o   (bank_gnt[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  // A port targets exactly one bank, so OR-ing the bank grants is safe.
  always_comb begin
    tcdm_gnt_o = '0;
    for (int b = 0; b < N_BANKS; b++) tcdm_gnt_o = tcdm_gnt_o | bank_gnt[b];
  end

  // Response regs. Read data only moves on a granted read and otherwise holds.
  always_comb begin
    r_valid_d = tcdm_gnt_o;
    r_data_d  = r_data_q;
    for (int p = 0; p < MP; p++)
      if (tcdm_gnt_o[p] && tcdm_wen_i[p]) r_data_d[p] = bank_rdata[bank_sel[p]];
    if (clear_i) begin
      r_valid_d = '0;
      r_data_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
endmodule

// File: tb/tb_nvdla_tcdm_responder.sv
// Directed bench for nvdla_tcdm_responder (MP=3, N_BANKS=4, MEM_WORDS=1024).
// A word-level memory model runs next to the DUT and checks every cycle.
// Literal expectations from hand-worked cases pin the model.
module tb_nvdla_tcdm_responder;
  localparam int MP = 3, NB = 4, MW = 1024;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic [MP-1:0]      req, gnt, wen, rv;
  logic [MP-1:0][31:0] add, data, rdata;
  logic [MP-1:0][3:0] be;

  int checks = 0;
  int errors = 0;

  nvdla_tcdm_responder #(.MP(MP), .N_BANKS(NB), .MEM_WORDS(MW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (data),
    .tcdm_r_data_o  (rdata),
    .tcdm_r_valid_o (rv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]   m_mem   [MW];
  bit            m_known [MW];
  int            m_rr    [NB];
  logic [MP-1:0] m_rv, m_isrd;
  logic [31:0]   m_rd    [MP];

  initial begin
    for (int i = 0; i < MW; i++) m_known[i] = 0;
    for (int b = 0; b < NB; b++) m_rr[b] = 0;
    m_rv = '0;
    m_isrd = '0;
  end

  always @(negedge clk) begin : model
    logic [MP-1:0] eg;
    int w, p;
    bit found;
    if (!rst_n) begin
      m_rv = '0;
      m_isrd = '0;
      for (int b = 0; b < NB; b++) m_rr[b] = 0;
    end
    // Expected grants: first requester of each bank at or after its pointer.
    eg = '0;
    for (int b = 0; b < NB; b++) begin
      found = 0;
      for (int k = 0; k < MP; k++) begin
        p = (m_rr[b] + k) % MP;
        if (!found && req[p] && (((add[p] >> 2) % NB) == b)) begin
          eg[p] = 1'b1;
          found = 1;
        end
      end
    end
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_rvalid", 32'(rv), 32'(m_rv));
    for (int q = 0; q < MP; q++)
      if (m_rv[q] && m_isrd[q]) chk("model_rdata", rdata[q], m_rd[q]);
    // Advance the model by one clock edge.
    if (rst_n) begin
      for (int q = 0; q < MP; q++) begin
        if (eg[q]) begin
          w = int'((add[q] >> 2) % MW);
          if (wen[q]) begin
            m_rd[q] = m_mem[w];
            if (!m_known[w]) m_isrd[q] = 1'b0;
            else m_isrd[q] = 1'b1;
          end else begin
            for (int bb = 0; bb < 4; bb++)
              if (be[q][bb]) m_mem[w][8*bb +: 8] = data[q][8*bb +: 8];
            if (be[q] == 4'hF) m_known[w] = 1;
            m_isrd[q] = 1'b0;
          end
          m_rr[((add[q] >> 2) % NB)] = (q + 1) % MP;
        end else begin
          m_isrd[q] = 1'b0;
        end
      end
      m_rv = eg;
      if (clear) begin
        m_rv = '0;
        for (int b = 0; b < NB; b++) m_rr[b] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    req = '0; wen = '1; be = '0; data = '0; add = '0; clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int p, input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; add[p] = a; wen[p] = w; be[p] = b; data[p] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rvalid", 32'(rv), 0);
    chk("reset_rdata0", rdata[0], 0);
    chk("reset_gnt", 32'(gnt), 0);
    step(); rst_n = 1'b1;

    // 3-way bank-0 conflict, each port drops req once granted
    drv(0, 32'h00, 1'b1, 4'h0, 0); drv(1, 32'h10, 1'b1, 4'h0, 0); drv(2, 32'h20, 1'b1, 4'h0, 0);
    @(negedge clk); chk("rr_gnt_c1", 32'(gnt), 32'b001);
    step(); req[0] = 1'b0;
    @(negedge clk); chk("rr_gnt_c2", 32'(gnt), 32'b010); chk("rr_rv_c2", 32'(rv), 32'b001);
    step(); req[1] = 1'b0;
    @(negedge clk); chk("rr_gnt_c3", 32'(gnt), 32'b100); chk("rr_rv_c3", 32'(rv), 32'b010);
    step(); idle();
    @(negedge clk); chk("rr_rv_c4", 32'(rv), 32'b100);

    // single-port write then read
    step(); drv(0, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF);
    @(negedge clk); chk("wr_gnt", 32'(gnt), 32'b001);
    step(); idle(); drv(0, 32'h40, 1'b1, 4'h0, 0);
    @(negedge clk); chk("rd_gnt", 32'(gnt), 32'b001); chk("wr_rv", 32'(rv), 32'b001);
    step(); idle();
    @(negedge clk); chk("rd_rv", 32'(rv), 32'b001); chk("rd_data", rdata[0], 32'hDEADBEEF);

    // byte enables
    step(); drv(1, 32'h80, 1'b0, 4'hF, 32'h11223344);
    step(); idle(); drv(1, 32'h80, 1'b0, 4'h5, 32'hAABBCCDD);
    step(); idle(); drv(1, 32'h80, 1'b1, 4'h0, 0);
    step(); idle();
    @(negedge clk); chk("be_rdata", rdata[1], 32'h11BB33DD);

    // conflict-free parallel writes and readback
    step(); drv(0, 32'h00, 1'b0, 4'hF, 32'hA0A00001);
    drv(1, 32'h04, 1'b0, 4'hF, 32'hB0B00002); drv(2, 32'h08, 1'b0, 4'hF, 32'hC0C00003);
    @(negedge clk); chk("par_wr_gnt", 32'(gnt), 32'b111);
    step(); idle();
    drv(0, 32'h00, 1'b1, 4'h0, 0); drv(1, 32'h04, 1'b1, 4'h0, 0); drv(2, 32'h08, 1'b1, 4'h0, 0);
    @(negedge clk); chk("par_rd_gnt", 32'(gnt), 32'b111);
    step(); idle();
    @(negedge clk);
    chk("par_rd0", rdata[0], 32'hA0A00001);
    chk("par_rd1", rdata[1], 32'hB0B00002);
    chk("par_rd2", rdata[2], 32'hC0C00003);

    // aliasing: 0x1004 wraps onto 0x4
    step(); drv(2, 32'h0000_1004, 1'b0, 4'hF, 32'h5A5A5A5A);
    step(); idle(); drv(0, 32'h04, 1'b1, 4'h0, 0);
    step(); idle();
    @(negedge clk); chk("alias_rdata", rdata[0], 32'h5A5A5A5A);

    // reset right after a granted read cancels the response
    step(); drv(0, 32'h40, 1'b1, 4'h0, 0);
    @(negedge clk); chk("rst_mid_gnt", 32'(gnt), 32'b001);
    step(); idle(); rst_n = 1'b0;
    @(negedge clk); chk("rst_mid_rv", 32'(rv), 0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("rst_after_rv", 32'(rv), 0);

    // move bank-0 pointer to 1, then clear while port 1 writes bank 1
    step(); drv(0, 32'h00, 1'b1, 4'h0, 0);
    step(); idle(); clear = 1'b1; drv(1, 32'h44, 1'b0, 4'hF, 32'h600DF00D);
    @(negedge clk); chk("clr_gnt", 32'(gnt), 32'b010);
    step(); idle();
    @(negedge clk); chk("clr_drop_rv", 32'(rv), 0);
    step(); drv(0, 32'h00, 1'b1, 4'h0, 0); drv(1, 32'h10, 1'b1, 4'h0, 0); drv(2, 32'h20, 1'b1, 4'h0, 0);
    @(negedge clk); chk("clr_rr_gnt", 32'(gnt), 32'b001);
    step(); req[0] = 1'b0;
    @(negedge clk); chk("clr_rr_gnt2", 32'(gnt), 32'b010);
    step(); idle(); drv(1, 32'h44, 1'b1, 4'h0, 0);
    step(); idle();
    @(negedge clk); chk("clr_wr_kept", rdata[1], 32'h600DF00D);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
